imm_ext_pipe: RTL and testbench
===============================

// Module: imm_ext_pipe
// PURPOSE
//  Registered, parametrised immediate-generation stage for the decode->execute path.
//  Extends an IMM_W-bit instruction immediate to DATA_W bits in one of four modes:
//  sign, zero, LUI-upper, branch-offset.
//  Valid/ready handshake on both sides with a 2-entry skid buffer, so the pipeline
//  can stall without combinational ready paths. Synchronous flush for branch/jump squash.
// PARAMETERS
//  IMM_W   16  immediate width taken from instruction
//  DATA_W  32  output datapath width; must satisfy DATA_W >= IMM_W+2
//  TAG_W   5   sideband tag (e.g. dest reg) carried alongside each result
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       reset, asynchronous, active-high
//  flush      in   1       synchronous squash of all held entries
//  in_valid   in   1       input beat valid
//  in_ready   out  1       stage can accept a beat (registered)
//  in_imm     in   IMM_W   raw immediate
//  in_mode    in   2       00 SEXT, 01 ZEXT, 10 LUI, 11 BOFS
//  in_tag     in   TAG_W   sideband, passed through unchanged
//  out_valid  out  1       result valid
//  out_ready  in   1       consumer accepts result
//  out_data   out  DATA_W  extended immediate
//  out_tag    out  TAG_W   tag of out_data
// BEHAVIOUR
//  Arithmetic (combinational ahead of the output register; m = IMM_W-1):
//   SEXT: {(DATA_W-IMM_W){imm[m]}, imm}. True two's-complement replication; no negation of low bits.
//   ZEXT: {(DATA_W-IMM_W){1'b0}, imm}.
//   LUI:  imm placed in bits [DATA_W-1 -: IMM_W]; all lower bits 0.
//   BOFS: SEXT result shifted left 2; upper bits truncated to DATA_W.
//  Storage: output reg (out_valid/out_data/out_tag) + one skid entry (skid_valid/data/tag).
//  in_ready = !skid_valid. Registered; never depends on out_ready in the same cycle.
//  Accept = in_valid & in_ready. Latency: accepted beat appears on out_* the next cycle.
//  Per clock, when flush=0:
//   - Output reg empty, or out_ready=1:
//     - skid_valid: skid moves to output; new accept (if any) goes to skid.
//     - otherwise: accept (if any) loads output; out_valid <= Accept.
//   - Output reg full and out_ready=0: output held stable (data, tag, valid);
//     accept (only possible when skid empty) loads skid.
//  Ordering strictly FIFO; no beat dropped or duplicated under any out_ready pattern.
//  out_data/out_tag must not change while out_valid=1 and out_ready=0.
//  flush=1: out_valid<=0, skid_valid<=0 next edge. Any same-cycle accept is discarded.
//   Flush wins over all simultaneous events. Data regs may keep stale values.
//  Reset (async, any time incl. mid-stall): out_valid=0, skid_valid=0 (in_ready=1),
//   out_data=0, out_tag=0, skid data/tag=0.
//  Full condition: output + skid both valid -> in_ready=0 until out_ready drains one.
//  in_imm/in_mode/in_tag ignored when in_valid=0; X-free outputs required after reset.
// TESTING
//  1 SEXT imm=16'h8000, out_ready=1 -> next cycle out_data=32'hFFFF8000, out_valid=1;
//    imm=16'h7FFF -> 32'h00007FFF.
//  2 ZEXT 16'hFFFF -> 32'h0000FFFF; LUI 16'h1234 -> 32'h12340000;
//    BOFS 16'hFFFF -> 32'hFFFFFFFC; BOFS 16'h0004 -> 32'h00000010.
//  3 Backpressure: out_ready=0, send tags 1,2 back-to-back -> in_ready=0 after 2nd;
//    out holds tag1; raise out_ready -> tags 1,2 emitted in order, in_ready=1 again.
//  4 Random in_valid/out_ready 10k beats vs reference queue model -> no loss,
//    duplication or reorder; out_* stable during stall.
//  5 flush with both entries full and in_valid=1 same cycle -> next cycle out_valid=0,
//    in_ready=1, no flushed beat ever emitted.
//  6 Assert rst mid-stall between edges -> out_valid=0, out_data=0, in_ready=1 immediately;
//    first beat after release emitted correctly.

Source files
------------

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: registered immediate-extension stage for decode->execute.
// Four extension modes (sign, zero, LUI-upper, branch offset). An output
// register plus one skid entry keep in_ready a pure register, so the
// upstream stage never sees a combinational path from out_ready.
module imm_ext_pipe #(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [1:0]        in_mode,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int PAD_W = DATA_W - IMM_W;

    typedef enum logic [1:0] {
        MODE_SEXT = 2'b00,
        MODE_ZEXT = 2'b01,
        MODE_LUI  = 2'b10,
        MODE_BOFS = 2'b11
    } mode_e;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [TAG_W-1:0]  out_tag_q,   out_tag_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [TAG_W-1:0]  skid_tag_q,   skid_tag_d;

    logic              accept;
    logic              out_free;
    logic [DATA_W-1:0] sext;
    logic [DATA_W-1:0] ext;

    // Extension arithmetic; branch offset reuses the sign-extended value.
    always_comb begin
        sext = {{PAD_W{in_imm[IMM_W-1]}}, in_imm};
        ext  = sext;
        case (mode_e'(in_mode))
            MODE_SEXT: ext = sext;
            MODE_ZEXT: ext = {{PAD_W{1'b0}}, in_imm};
            MODE_LUI:  ext = {in_imm, {PAD_W{1'b0}}};
            MODE_BOFS: ext = {sext[DATA_W-3:0], 2'b00};
            default:   ext = sext;
        endcase
    end

    // Skid entry empty <=> room for one more beat; taken straight from a flop.
    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready;
    assign out_free = !out_valid_q || out_ready;

    // Next-state for output register and skid entry; flush overrides everything.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_tag_d    = out_tag_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_tag_d   = skid_tag_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                // Oldest beat lives in skid: promote it, refill skid if possible.
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_tag_d    = skid_tag_q;
                skid_valid_d = accept;
                if (accept) begin
                    skid_data_d = ext;
                    skid_tag_d  = in_tag;
                end
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_data_d = ext;
                    out_tag_d  = in_tag;
                end
            end
        end else if (accept) begin
            // Consumer stalled with output full: park the new beat in skid.
            skid_valid_d = 1'b1;
            skid_data_d  = ext;
            skid_tag_d   = in_tag;
        end
    end

    // State registers, cleared asynchronously so outputs are X-free after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_tag_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_tag_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_tag_q    <= out_tag_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_tag_q   <= skid_tag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe: the driver pushes the expected result of
// every accepted beat; an independent monitor pops on each output handshake
// and also checks output stability while the consumer stalls.
module tb_imm_ext_pipe;

    localparam int IMM_W  = 16;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 5;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [IMM_W-1:0]  in_imm = '0;
    logic [1:0]        in_mode = '0;
    logic [TAG_W-1:0]  in_tag = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;

    int   errors = 0;
    int   checks = 0;
    exp_t sbq[$];

    imm_ext_pipe #(.IMM_W(IMM_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    // Reference: value of the immediate as an integer, scaled per mode, kept mod 2^DATA_W.
    function automatic logic [DATA_W-1:0] model(input logic [IMM_W-1:0] imm, input logic [1:0] mode);
        longint s;
        longint u;
        longint v;
        s = longint'($signed(imm));
        u = longint'(imm);
        case (mode)
            2'd0:    v = s;
            2'd1:    v = u;
            2'd2:    v = u * (longint'(1) << (DATA_W - IMM_W));
            default: v = s * 4;
        endcase
        return v[DATA_W-1:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // One cycle of stimulus; acceptance is judged at the negedge, away from the edge.
    task automatic beat(input logic v, input logic [IMM_W-1:0] imm, input logic [1:0] mode,
                        input logic [TAG_W-1:0] tag, input logic ordy, input logic fl);
        exp_t e;
        in_valid  = v;
        in_imm    = imm;
        in_mode   = mode;
        in_tag    = tag;
        flush     = fl;
        out_ready = fl ? 1'b0 : ordy;
        @(negedge clk);
        if (fl) sbq.delete();
        else if (v && in_ready) begin
            e.data = model(imm, mode);
            e.tag  = tag;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop/compare on handshake; enforce hold while stalled.
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data;
    logic [TAG_W-1:0]  prev_tag;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_data", 64'(out_data), 64'(prev_data));
                chk("stall_tag", 64'(out_tag), 64'(prev_tag));
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data %0h tag %0h expected none", out_data, out_tag);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_data", 64'(out_data), 64'(e.data));
                    chk("sb_tag", 64'(out_tag), 64'(e.tag));
                end
            end
            prev_stall = out_valid && !out_ready && !flush;
            prev_data  = out_data;
            prev_tag   = out_tag;
        end
    end

    initial begin
        int cnt;
        // Reset state
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Mode arithmetic, streaming with out_ready=1
        beat(1, 16'h8000, 2'd0, 5'd1, 1, 0);
        chk("sext_8000_valid", 64'(out_valid), 64'd1);
        chk("sext_8000", 64'(out_data), 64'hFFFF8000);
        beat(1, 16'h7FFF, 2'd0, 5'd2, 1, 0);
        chk("sext_7fff", 64'(out_data), 64'h00007FFF);
        beat(1, 16'hFFFF, 2'd1, 5'd3, 1, 0);
        chk("zext_ffff", 64'(out_data), 64'h0000FFFF);
        beat(1, 16'h1234, 2'd2, 5'd4, 1, 0);
        chk("lui_1234", 64'(out_data), 64'h12340000);
        beat(1, 16'hFFFF, 2'd3, 5'd5, 1, 0);
        chk("bofs_ffff", 64'(out_data), 64'hFFFFFFFC);
        beat(1, 16'h0004, 2'd3, 5'd6, 1, 0);
        chk("bofs_0004", 64'(out_data), 64'h00000010);
        chk("bofs_tag", 64'(out_tag), 64'd6);
        beat(0, '0, 2'd0, '0, 1, 0);
        chk("drain_valid", 64'(out_valid), 64'd0);

        // Backpressure fills output then skid
        beat(1, 16'h0011, 2'd1, 5'd1, 0, 0);
        chk("bp_in_ready_1", 64'(in_ready), 64'd1);
        beat(1, 16'h0022, 2'd1, 5'd2, 0, 0);
        chk("bp_in_ready_full", 64'(in_ready), 64'd0);
        chk("bp_hold_tag1", 64'(out_tag), 64'd1);
        beat(1, 16'h0033, 2'd1, 5'd3, 0, 0);   // refused: skid full
        chk("bp_still_tag1", 64'(out_tag), 64'd1);
        beat(0, '0, 2'd0, '0, 1, 0);
        chk("bp_tag2_next", 64'(out_tag), 64'd2);
        chk("bp_in_ready_again", 64'(in_ready), 64'd1);
        beat(0, '0, 2'd0, '0, 1, 0);
        chk("bp_empty", 64'(out_valid), 64'd0);

        // Flush while full with a beat offered
        beat(1, 16'h0101, 2'd0, 5'd9, 0, 0);
        beat(1, 16'h0202, 2'd0, 5'd10, 0, 0);
        beat(1, 16'h0303, 2'd0, 5'd11, 0, 1);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        // Flush with empty stage and an accepted beat: beat discarded
        beat(1, 16'h0404, 2'd0, 5'd12, 1, 1);
        chk("flush_accept_dropped", 64'(out_valid), 64'd0);
        beat(0, '0, 2'd0, '0, 1, 0);
        beat(0, '0, 2'd0, '0, 1, 0);
        chk("flush_nothing_emitted", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-stall
        beat(1, 16'h0505, 2'd1, 5'd13, 0, 0);
        beat(1, 16'h0606, 2'd1, 5'd14, 0, 0);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_data", 64'(out_data), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        sbq.delete();
        @(negedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        beat(1, 16'h8001, 2'd0, 5'd7, 1, 0);
        chk("post_rst_data", 64'(out_data), 64'hFFFF8001);
        chk("post_rst_tag", 64'(out_tag), 64'd7);
        beat(0, '0, 2'd0, '0, 1, 0);

        // Random traffic with occasional flush
        for (int i = 0; i < 10000; i++) begin
            beat(($urandom_range(0, 3) != 0), IMM_W'($urandom), 2'($urandom), TAG_W'($urandom),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 63) == 0));
        end
        cnt = 0;
        while (sbq.size() != 0 && cnt < 50) begin
            beat(0, '0, 2'd0, '0, 1, 0);
            cnt++;
        end
        chk("drain_queue_empty", 64'(sbq.size()), 64'd0);
        chk("final_out_valid", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
